// File: rtl/fifo_status.sv
// Synchronous FIFO with occupancy status flags and overflow/underflow pulses.
// Occupancy is derived from the read/write pointers and their lap bits.
module fifo_status #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 10,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wr_data,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    if (WIDTH < 1) begin : g_bad_width
        $fatal(1, "fifo_status: WIDTH must be >= 1");
    end
    if (DEPTH < 2) begin : g_bad_depth
        $fatal(1, "fifo_status: DEPTH must be >= 2");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
        $fatal(1, "fifo_status: AF_LEVEL must be in 1..DEPTH");
    end
    if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
        $fatal(1, "fifo_status: AE_LEVEL must be in 0..DEPTH-1");
    end
    if (FWFT != 0 && FWFT != 1) begin : g_bad_fwft
        $fatal(1, "fifo_status: FWFT must be 0 or 1");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic             wr_lap_q, wr_lap_d, rd_lap_q, rd_lap_d;
    logic             overflow_q, underflow_q;
    logic             push_ok, pop_ok;

    // Lap bits disambiguate full from empty when the pointers coincide.
    always_comb begin
        if (wr_lap_q == rd_lap_q) begin
            count = CW'(wr_ptr_q) - CW'(rd_ptr_q);
        end else begin
            count = CW'(DEPTH) + CW'(wr_ptr_q) - CW'(rd_ptr_q);
        end
    end

    assign full         = (count == CW'(DEPTH));
    assign empty        = (count == '0);
    assign almost_full  = (count >= CW'(AF_LEVEL));
    assign almost_empty = (count <= CW'(AE_LEVEL));

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        wr_lap_d = wr_lap_q;
        rd_ptr_d = rd_ptr_q;
        rd_lap_d = rd_lap_q;
        if (push_ok) begin
            if (wr_ptr_q == PW'(DEPTH - 1)) begin
                wr_ptr_d = '0;
                wr_lap_d = ~wr_lap_q;
            end else begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
        end
        if (pop_ok) begin
            if (rd_ptr_q == PW'(DEPTH - 1)) begin
                rd_ptr_d = '0;
                rd_lap_d = ~rd_lap_q;
            end else begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            wr_lap_q    <= 1'b0;
            rd_lap_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_lap_q    <= wr_lap_d;
            rd_lap_q    <= rd_lap_d;
            overflow_q  <= push && full;
            underflow_q <= pop && empty;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    if (FWFT != 0) begin : g_fwft
        assign rd_data = mem_q[rd_ptr_q];
    end else begin : g_reg_rd
        logic [WIDTH-1:0] rd_data_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_data_q <= '0;
            end else if (pop_ok) begin
                rd_data_q <= mem_q[rd_ptr_q];
            end
        end
        assign rd_data = rd_data_q;
    end

endmodule

// File: tb/tb_fifo_status.sv
// Bench for fifo_status: registered-read and FWFT instances share one stimulus
// stream and are checked against a queue model of the FIFO contents.
module tb_fifo_status;

    localparam int DEPTH = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic [7:0] wr_data = 8'h00;

    logic [7:0] rd_data_r, rd_data_f;
    logic       full_r, empty_r, af_r, ae_r, ovf_r, udf_r;
    logic       full_f, empty_f, af_f, ae_f, ovf_f, udf_f;
    logic [3:0] count_r, count_f;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] mq[$];
    logic [7:0] rd_reg_m = 8'h00;

    always #5 clk = ~clk;

    fifo_status #(.WIDTH(8), .DEPTH(DEPTH), .FWFT(0)) u_reg (
        .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .wr_data(wr_data),
        .rd_data(rd_data_r), .full(full_r), .empty(empty_r),
        .almost_full(af_r), .almost_empty(ae_r), .count(count_r),
        .overflow(ovf_r), .underflow(udf_r)
    );

    fifo_status #(.WIDTH(8), .DEPTH(DEPTH), .FWFT(1)) u_fwft (
        .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .wr_data(wr_data),
        .rd_data(rd_data_f), .full(full_f), .empty(empty_f),
        .almost_full(af_f), .almost_empty(ae_f), .count(count_f),
        .overflow(ovf_f), .underflow(udf_f)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_flags();
        int n;
        n = mq.size();
        check_val("count_r", 32'(count_r), 32'(n));
        check_val("count_f", 32'(count_f), 32'(n));
        check_val("full", {30'd0, full_r, full_f}, (n == DEPTH) ? 32'd3 : 32'd0);
        check_val("empty", {30'd0, empty_r, empty_f}, (n == 0) ? 32'd3 : 32'd0);
        check_val("almost_full", {30'd0, af_r, af_f}, (n >= DEPTH - 2) ? 32'd3 : 32'd0);
        check_val("almost_empty", {30'd0, ae_r, ae_f}, (n <= 2) ? 32'd3 : 32'd0);
    endtask

    // Called at the falling edge; returns at the next falling edge.
    task automatic step(input logic p, input logic q, input logic [7:0] d);
        logic exp_ovf, exp_udf;
        push = p;
        pop = q;
        wr_data = d;
        if (mq.size() != 0) check_val("fwft_head", 32'(rd_data_f), 32'(mq[0]));
        exp_ovf = p && (mq.size() == DEPTH);
        exp_udf = q && (mq.size() == 0);
        if (q && mq.size() != 0) rd_reg_m = mq.pop_front();
        if (p && !exp_ovf) mq.push_back(d);
        @(posedge clk);
        #1;
        check_flags();
        check_val("overflow", {30'd0, ovf_r, ovf_f}, exp_ovf ? 32'd3 : 32'd0);
        check_val("underflow", {30'd0, udf_r, udf_f}, exp_udf ? 32'd3 : 32'd0);
        check_val("rd_data_reg", 32'(rd_data_r), 32'(rd_reg_m));
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] seq;
        // Reset state, held across a few edges
        repeat (3) @(posedge clk);
        #1;
        check_flags();
        check_val("rst_ovf_udf", {30'd0, ovf_r, udf_r}, 32'd0);
        check_val("rst_rd_data", 32'(rd_data_r), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Fill 0x01..0x0A, then overflow attempt, then drain
        for (int i = 1; i <= DEPTH; i++) step(1'b1, 1'b0, 8'(i));
        step(1'b1, 1'b0, 8'hFF);
        step(1'b0, 1'b0, 8'h00);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 8'h00);

        // Underflow on empty, then push+pop on empty
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b1, 8'h3C);
        step(1'b0, 1'b1, 8'h00);

        // Steady state at count=5 across several pointer wraps
        seq = 8'h40;
        for (int i = 0; i < 5; i++) begin step(1'b1, 1'b0, seq); seq++; end
        for (int i = 0; i < 30; i++) begin step(1'b1, 1'b1, seq); seq++; end

        // Push+pop while full
        for (int i = 0; i < 5; i++) begin step(1'b1, 1'b0, seq); seq++; end
        step(1'b1, 1'b1, 8'hFF);

        // Random traffic
        for (int i = 0; i < 200; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
        end

        // Bring occupancy to 7 then reset asynchronously between edges
        while (mq.size() > 7) step(1'b0, 1'b1, 8'h00);
        while (mq.size() < 7) begin step(1'b1, 1'b0, seq); seq++; end
        push = 1'b1;
        wr_data = 8'hEE;
        #2;
        rst_n = 1'b0;
        #1;
        mq.delete();
        rd_reg_m = 8'h00;
        check_flags();
        check_val("async_rst_rd_data", 32'(rd_data_r), 32'd0);
        // Push held while reset is low must not be taken at this edge
        @(posedge clk);
        #1;
        check_flags();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 1'b0, 8'h55);
        step(1'b1, 1'b0, 8'h66);
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
